// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between an instruction-fetch
// port (port 0, read-only) and a data port (port 1, read/write).
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   mem_read_0, mem_address_0        fetch request (held until mem_resp_0)
//   mem_rdata_0, mem_resp_0          fetch data / completion pulse
//   mem_read_1, mem_write_1          data-port request (held until mem_resp_1)
//   mem_address_1, mem_wdata_1,
//   mem_byte_enable_1                data-port request fields
//   mem_rdata_1, mem_resp_1          data-port data / completion pulse
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata,
//   pmem_byte_enable                 physical memory request (registered)
//   pmem_rdata, pmem_resp            physical memory data / completion
//   stall                            pipeline hold while any port is pending
//
// Parameter PORT1_PRIORITY: 1 = data port wins ties, 0 = alternate on ties.
//
// state  | meaning
// IDLE   | no transaction; arbitrate pending requests
// SERVE0 | fetch port owns physical memory, waiting for pmem_resp
// SERVE1 | data port owns physical memory, waiting for pmem_resp

module mem_arbiter #(
  parameter bit PORT1_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_0,
  input  logic [15:0] mem_address_0,
  output logic [15:0] mem_rdata_0,
  output logic        mem_resp_0,
  input  logic        mem_read_1,
  input  logic        mem_write_1,
  input  logic [15:0] mem_address_1,
  input  logic [15:0] mem_wdata_1,
  input  logic [1:0]  mem_byte_enable_1,
  output logic [15:0] mem_rdata_1,
  output logic        mem_resp_1,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t      state;
  logic        last_grant;
  logic [15:0] lat_address;
  logic [15:0] lat_wdata;
  logic [1:0]  lat_byte_enable;
  logic        lat_write;

  logic req_0;
  logic req_1;
  logic pick_1;
  logic serve_0;
  logic serve_1;

  assign req_0 = mem_read_0;
  assign req_1 = mem_read_1 | mem_write_1;

  // Port 1 wins when alone, or on a tie when it has fixed priority or
  // port 0 held the previous grant.
  assign pick_1 = req_1 & (~req_0 | PORT1_PRIORITY | ~last_grant);

  // Latched fields are cleared on completion so the physical request bus
  // reads as zero whenever the arbiter is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      lat_address     <= '0;
      lat_wdata       <= '0;
      lat_byte_enable <= '0;
      lat_write       <= 1'b0;
      pmem_read       <= 1'b0;
      pmem_write      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_1) begin
            state           <= SERVE1;
            last_grant      <= 1'b1;
            lat_address     <= mem_address_1;
            lat_wdata       <= mem_wdata_1;
            lat_byte_enable <= mem_byte_enable_1;
            lat_write       <= mem_write_1;
            pmem_read       <= ~mem_write_1;
            pmem_write      <= mem_write_1;
          end else if (req_0) begin
            state           <= SERVE0;
            last_grant      <= 1'b0;
            lat_address     <= mem_address_0;
            lat_wdata       <= '0;
            lat_byte_enable <= 2'b11;
            lat_write       <= 1'b0;
            pmem_read       <= 1'b1;
            pmem_write      <= 1'b0;
          end
        end
        SERVE0, SERVE1: begin
          if (pmem_resp) begin
            state           <= IDLE;
            lat_address     <= '0;
            lat_wdata       <= '0;
            lat_byte_enable <= '0;
            lat_write       <= 1'b0;
            pmem_read       <= 1'b0;
            pmem_write      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_address     = lat_address;
  assign pmem_wdata       = lat_wdata;
  assign pmem_byte_enable = lat_byte_enable;

  assign serve_0 = (state == SERVE0);
  assign serve_1 = (state == SERVE1);

  assign mem_resp_0  = serve_0 & pmem_resp;
  assign mem_resp_1  = serve_1 & pmem_resp;
  assign mem_rdata_0 = serve_0 ? pmem_rdata : '0;
  assign mem_rdata_1 = serve_1 ? pmem_rdata : '0;

  assign stall = (req_0 & ~mem_resp_0) | (req_1 & ~mem_resp_1);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: one instance with port-1 priority driven by a
// latency-programmable memory model and a transaction scoreboard, plus a
// round-robin instance with a zero-wait memory for grant-order checks.

module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_read_0;
  logic [15:0] mem_address_0;
  logic [15:0] mem_rdata_0;
  logic        mem_resp_0;
  logic        mem_read_1, mem_write_1;
  logic [15:0] mem_address_1, mem_wdata_1;
  logic [1:0]  mem_byte_enable_1;
  logic [15:0] mem_rdata_1;
  logic        mem_resp_1;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_address, pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;
  logic        stall;
  logic        auto_resp, force_resp;

  assign pmem_resp = auto_resp | force_resp;

  logic        rr_read_0, rr_read_1;
  logic [15:0] rr_rdata_0, rr_rdata_1, rr_paddr, rr_pwdata;
  logic        rr_resp_0, rr_resp_1, rr_pread, rr_pwrite, rr_stall;
  logic [1:0]  rr_pbe;
  logic        rr_pmem_resp = 1'b1;
  logic [15:0] rr_pmem_rdata = 16'h0000;
  logic [15:0] rr_zero16 = 16'h0000;
  logic [1:0]  rr_zero2 = 2'b00;
  logic        rr_zero1 = 1'b0;

  mem_arbiter #(.PORT1_PRIORITY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .mem_read_0(mem_read_0), .mem_address_0(mem_address_0),
    .mem_rdata_0(mem_rdata_0), .mem_resp_0(mem_resp_0),
    .mem_read_1(mem_read_1), .mem_write_1(mem_write_1),
    .mem_address_1(mem_address_1), .mem_wdata_1(mem_wdata_1),
    .mem_byte_enable_1(mem_byte_enable_1),
    .mem_rdata_1(mem_rdata_1), .mem_resp_1(mem_resp_1),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .stall(stall)
  );

  mem_arbiter #(.PORT1_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .reset(reset),
    .mem_read_0(rr_read_0), .mem_address_0(rr_zero16),
    .mem_rdata_0(rr_rdata_0), .mem_resp_0(rr_resp_0),
    .mem_read_1(rr_read_1), .mem_write_1(rr_zero1),
    .mem_address_1(rr_zero16), .mem_wdata_1(rr_zero16),
    .mem_byte_enable_1(rr_zero2),
    .mem_rdata_1(rr_rdata_1), .mem_resp_1(rr_resp_1),
    .pmem_read(rr_pread), .pmem_write(rr_pwrite),
    .pmem_address(rr_paddr), .pmem_wdata(rr_pwdata),
    .pmem_byte_enable(rr_pbe),
    .pmem_rdata(rr_pmem_rdata), .pmem_resp(rr_pmem_resp),
    .stall(rr_stall)
  );

  typedef struct {
    bit          port;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    bit          write;
  } txn_t;

  txn_t sb[$];
  int   rr_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mem_lat = 3;
  int   wait_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_model(input logic [15:0] a);
    return a ^ 16'h1274;
  endfunction

  function automatic void push_txn(input bit port, input logic [15:0] addr,
                                   input logic [15:0] wdata, input logic [1:0] be,
                                   input bit write);
    txn_t t;
    t.port = port; t.addr = addr; t.wdata = wdata; t.be = be; t.write = write;
    sb.push_back(t);
  endfunction

  // Memory model: responds in the mem_lat-th cycle of a physical request.
  initial begin
    auto_resp  = 1'b0;
    pmem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk); #1;
      if (pmem_read | pmem_write) begin
        wait_cnt++;
        auto_resp  = (wait_cnt == mem_lat);
        pmem_rdata = rd_model(pmem_address);
      end else begin
        wait_cnt   = 0;
        auto_resp  = 1'b0;
        pmem_rdata = 16'hDEAD;
      end
    end
  end

  task automatic monitor();
    logic active, e0, e1;
    active = pmem_read | pmem_write;
    e0 = 1'b0;
    e1 = 1'b0;
    if (active) begin
      if (sb.size() == 0) begin
        chk("unexpected_req", active, 0);
      end else begin
        chk("pmem_address", pmem_address, sb[0].addr);
        chk("pmem_be", pmem_byte_enable, sb[0].be);
        chk("pmem_write", pmem_write, sb[0].write);
        chk("pmem_read", pmem_read, !sb[0].write);
        if (sb[0].write) chk("pmem_wdata", pmem_wdata, sb[0].wdata);
        e0 = pmem_resp & !sb[0].port;
        e1 = pmem_resp & sb[0].port;
      end
    end else begin
      chk("idle_addr_wdata", {pmem_address, pmem_wdata}, 0);
      chk("idle_be", pmem_byte_enable, 0);
      chk("idle_rdata", {mem_rdata_0, mem_rdata_1}, 0);
    end
    chk("mem_resp_0", mem_resp_0, e0);
    chk("mem_resp_1", mem_resp_1, e1);
    if (e0) chk("mem_rdata_0", mem_rdata_0, rd_model(sb[0].addr));
    if (e1 && !sb[0].write) chk("mem_rdata_1", mem_rdata_1, rd_model(sb[0].addr));
    chk("stall", stall, (mem_read_0 & ~e0) | ((mem_read_1 | mem_write_1) & ~e1));
    if (e0 | e1) void'(sb.pop_front());
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) monitor();
  end

  initial forever begin
    @(negedge clk);
    if (!reset && (rr_resp_0 | rr_resp_1)) begin
      chk("rr_onehot", rr_resp_0 & rr_resp_1, 0);
      if (rr_q.size() > 0) begin
        chk("rr_order", rr_resp_1, rr_q[0]);
        void'(rr_q.pop_front());
      end else begin
        chk("rr_extra", rr_resp_0 | rr_resp_1, 0);
      end
    end
  end

  task automatic wait_resp(input bit port, input string tag,
                           output logic [15:0] rdata, output int at_cyc);
    bit seen;
    seen   = 1'b0;
    rdata  = '0;
    at_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (port ? mem_resp_1 : mem_resp_0) begin
        seen   = 1'b1;
        rdata  = port ? mem_rdata_1 : mem_rdata_0;
        at_cyc = cyc;
        break;
      end
    end
    chk(tag, seen, 1);
    @(posedge clk); #1;
  endtask

  logic [15:0] rd;
  int          c0, c1, c2, tmp;

  initial begin
    reset = 1'b1; force_resp = 1'b0;
    mem_read_0 = 0; mem_address_0 = 0;
    mem_read_1 = 0; mem_write_1 = 0; mem_address_1 = 0; mem_wdata_1 = 0; mem_byte_enable_1 = 0;
    rr_read_0 = 0; rr_read_1 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {pmem_read, pmem_write, mem_resp_0, mem_resp_1, stall}, 0);
    chk("rst_rr_outputs", {rr_pread, rr_pwrite, rr_stall}, 0);

    // single fetch, memory answers in the third service cycle
    @(posedge clk); #1;
    mem_lat = 3;
    push_txn(0, 16'h0040, 16'h0000, 2'b11, 0);
    mem_read_0 = 1; mem_address_0 = 16'h0040;
    wait_resp(0, "fetch_resp", rd, tmp);
    chk("fetch_rdata", rd, 16'h1234);
    mem_read_0 = 0;

    // collision: data port first, fetch after one idle cycle
    @(posedge clk); #1;
    push_txn(1, 16'h0100, 16'h7777, 2'b11, 0);
    push_txn(0, 16'h0300, 16'h0000, 2'b11, 0);
    mem_read_1 = 1; mem_address_1 = 16'h0100; mem_wdata_1 = 16'h7777; mem_byte_enable_1 = 2'b11;
    mem_read_0 = 1; mem_address_0 = 16'h0300;
    fork
      begin logic [15:0] r; int t; wait_resp(1, "coll_resp1", r, t); mem_read_1 = 0; end
      begin logic [15:0] r; int t; wait_resp(0, "coll_resp0", r, t); mem_read_0 = 0; end
    join

    // write with requester fields changing mid-service
    @(posedge clk); #1;
    mem_lat = 4;
    push_txn(1, 16'h0200, 16'hBEEF, 2'b01, 1);
    mem_write_1 = 1; mem_address_1 = 16'h0200; mem_wdata_1 = 16'hBEEF; mem_byte_enable_1 = 2'b01;
    fork
      begin logic [15:0] r; int t; wait_resp(1, "write_resp", r, t); end
      begin
        repeat (2) @(posedge clk);
        #2;
        mem_address_1 = 16'hFFFF; mem_wdata_1 = 16'h0000; mem_byte_enable_1 = 2'b10; mem_read_1 = 1;
      end
    join
    mem_write_1 = 0; mem_read_1 = 0;

    // read and write both high counts as a write
    @(posedge clk); #1;
    mem_lat = 2;
    push_txn(1, 16'h0210, 16'h1111, 2'b11, 1);
    mem_read_1 = 1; mem_write_1 = 1; mem_address_1 = 16'h0210; mem_wdata_1 = 16'h1111; mem_byte_enable_1 = 2'b11;
    wait_resp(1, "rw_resp", rd, tmp);
    mem_read_1 = 0; mem_write_1 = 0;

    // reset while the data port is waiting aborts the write
    @(posedge clk); #1;
    mem_lat = 1000;
    push_txn(1, 16'h0220, 16'hCAFE, 2'b10, 1);
    mem_write_1 = 1; mem_address_1 = 16'h0220; mem_wdata_1 = 16'hCAFE; mem_byte_enable_1 = 2'b10;
    tmp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_write) begin tmp = 1; break; end
    end
    chk("abort_started", tmp, 1);
    @(posedge clk); #1;
    reset = 1'b1; mem_write_1 = 0;
    @(posedge clk); #1;
    reset = 1'b0; sb.delete(); force_resp = 1'b1;
    @(negedge clk);
    chk("abort_pmem_write", pmem_write, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_resp1", mem_resp_1, 0);
    end
    @(posedge clk); #1;
    force_resp = 1'b0;
    mem_lat = 3;

    // zero-wait memory: held fetch completes every second cycle
    @(posedge clk); #1;
    mem_lat = 1;
    push_txn(0, 16'h0500, 16'h0000, 2'b11, 0);
    push_txn(0, 16'h0502, 16'h0000, 2'b11, 0);
    push_txn(0, 16'h0504, 16'h0000, 2'b11, 0);
    mem_read_0 = 1; mem_address_0 = 16'h0500;
    wait_resp(0, "zw_resp_a", rd, c0);
    mem_address_0 = 16'h0502;
    wait_resp(0, "zw_resp_b", rd, c1);
    mem_address_0 = 16'h0504;
    wait_resp(0, "zw_resp_c", rd, c2);
    mem_read_0 = 0;
    chk("zw_spacing_ab", c1 - c0, 2);
    chk("zw_spacing_bc", c2 - c1, 2);

    // round-robin instance: continuous requests alternate starting at port 0
    @(posedge clk); #1;
    rr_q.push_back(0); rr_q.push_back(1); rr_q.push_back(0); rr_q.push_back(1);
    rr_read_0 = 1; rr_read_1 = 1;
    tmp = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rr_resp_0 | rr_resp_1) tmp++;
      if (tmp == 4) break;
    end
    @(posedge clk); #1;
    rr_read_0 = 0; rr_read_1 = 0;
    chk("rr_count", tmp, 4);
    chk("rr_queue_empty", rr_q.size(), 0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
